// File: rtl/scc_pkg.sv
// rtl/scc_pkg.sv - shared constants and types for the SCC register bank
// Purpose: channel count, register-map base offsets, slot type and the
//          slot-advance helper used by the register bank.
// Ports:   none (package).
package scc_pkg;

    localparam int SCC_CH_NUM = 6;

    localparam logic [4:0] SCC_ADR_FREQ   = 5'h00;
    localparam logic [4:0] SCC_ADR_VOL    = 5'h0C;
    localparam logic [4:0] SCC_ADR_ENABLE = 5'h12;

    typedef logic [2:0] scc_slot_t;

    localparam scc_slot_t SCC_SLOT_LAST = 3'(SCC_CH_NUM - 1);

    // Slot sequence wraps 5 -> 0, so the codes 6 and 7 are never produced.
    function automatic scc_slot_t scc_next_slot(input scc_slot_t slot);
        return (slot == SCC_SLOT_LAST) ? 3'd0 : slot + 3'd1;
    endfunction

endpackage

// File: rtl/scc_channel_reg.sv
// rtl/scc_channel_reg.sv - one channel's frequency, volume and pending-reload flag
// Purpose: holds freq/vol for a single SCC channel and tracks whether the slot
//          engine still has to pick up a new frequency.
// Ports:   clk, reset_n      - clock, async active-low reset
//          wr_lo, wr_hi      - decoded writes to freq low byte / high part
//          wr_vol            - decoded write to the volume register
//          wdata             - bus write data
//          consume           - slot engine has serviced this channel
//          freq, vol         - register contents
//          pending           - frequency changed since last consume
module scc_channel_reg #(
    parameter int bits     = 12,
    parameter int vol_bits = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_lo,
    input  logic                wr_hi,
    input  logic                wr_vol,
    input  logic [7:0]          wdata,
    input  logic                consume,
    output logic [bits-1:0]     freq,
    output logic [vol_bits-1:0] vol,
    output logic                pending
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            freq    <= '0;
            vol     <= '0;
            pending <= 1'b0;
        end else begin
            if (wr_lo) begin
                freq[7:0] <= wdata;
            end
            if (wr_hi) begin
                freq[bits-1:8] <= wdata[bits-9:0];
            end
            if (wr_vol) begin
                vol <= wdata[vol_bits-1:0];
            end
            // A frequency write in the same cycle as consume must survive,
            // otherwise the slot engine would miss the new value.
            if (wr_lo || wr_hi) begin
                pending <= 1'b1;
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/scc_register_bank.sv
// rtl/scc_register_bank.sv - SCC write-side register bank with slot counter
// Purpose: decodes CPU bus accesses into six channel registers and the
//          channel-enable mask, provides registered read-back, and owns the
//          time-slot counter that hands pending reloads to the slot engine.
// Ports:   clk, reset_n                 - clock, async active-low reset
//          bus_wr, bus_rd               - one-cycle write / read strobes
//          bus_address, bus_wdata       - register offset, write data
//          bus_rdata, bus_rdata_en      - registered read data and valid pulse
//          slot_en                      - advance slot, consume reload flag
//          active, reload               - current slot and its pending reload
//          freq_a..freq_f, vol_a..vol_f - channel 0..5 frequency / volume
//          ch_enable                    - per-channel enable mask
module scc_register_bank
    import scc_pkg::*;
#(
    parameter int bits     = 12,
    parameter int vol_bits = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                bus_wr,
    input  logic                bus_rd,
    input  logic [4:0]          bus_address,
    input  logic [7:0]          bus_wdata,
    output logic [7:0]          bus_rdata,
    output logic                bus_rdata_en,
    input  logic                slot_en,
    output logic [2:0]          active,
    output logic                reload,
    output logic [bits-1:0]     freq_a,
    output logic [bits-1:0]     freq_b,
    output logic [bits-1:0]     freq_c,
    output logic [bits-1:0]     freq_d,
    output logic [bits-1:0]     freq_e,
    output logic [bits-1:0]     freq_f,
    output logic [vol_bits-1:0] vol_a,
    output logic [vol_bits-1:0] vol_b,
    output logic [vol_bits-1:0] vol_c,
    output logic [vol_bits-1:0] vol_d,
    output logic [vol_bits-1:0] vol_e,
    output logic [vol_bits-1:0] vol_f,
    output logic [5:0]          ch_enable
);

    logic [SCC_CH_NUM-1:0] wr_lo;
    logic [SCC_CH_NUM-1:0] wr_hi;
    logic [SCC_CH_NUM-1:0] wr_vol;
    logic [SCC_CH_NUM-1:0] consume;
    logic [SCC_CH_NUM-1:0] pending;
    logic [bits-1:0]       freq_arr   [SCC_CH_NUM];
    logic [vol_bits-1:0]   vol_arr    [SCC_CH_NUM];
    logic [7:0]            freq_lo_rd [SCC_CH_NUM];
    logic [7:0]            freq_hi_rd [SCC_CH_NUM];
    logic [7:0]            vol_rd     [SCC_CH_NUM];
    logic [7:0]            rd_value;
    logic [7:0]            pending_ext;
    scc_slot_t             slot;

    always_comb begin
        wr_lo  = '0;
        wr_hi  = '0;
        wr_vol = '0;
        for (int n = 0; n < SCC_CH_NUM; n++) begin
            wr_lo[n]  = bus_wr && (bus_address == SCC_ADR_FREQ + 5'(2 * n));
            wr_hi[n]  = bus_wr && (bus_address == SCC_ADR_FREQ + 5'(2 * n + 1));
            wr_vol[n] = bus_wr && (bus_address == SCC_ADR_VOL + 5'(n));
        end
    end

    for (genvar n = 0; n < SCC_CH_NUM; n++) begin : g_ch
        assign consume[n] = slot_en && (slot == 3'(n));

        scc_channel_reg #(
            .bits     (bits),
            .vol_bits (vol_bits)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .wr_lo   (wr_lo[n]),
            .wr_hi   (wr_hi[n]),
            .wr_vol  (wr_vol[n]),
            .wdata   (bus_wdata),
            .consume (consume[n]),
            .freq    (freq_arr[n]),
            .vol     (vol_arr[n]),
            .pending (pending[n])
        );

        assign freq_lo_rd[n] = freq_arr[n][7:0];
        assign freq_hi_rd[n] = 8'(freq_arr[n][bits-1:8]);
        assign vol_rd[n]     = 8'(vol_arr[n]);
    end

    // Unmapped offsets read as all ones; every mapped offset overrides it.
    always_comb begin
        rd_value = 8'hFF;
        for (int n = 0; n < SCC_CH_NUM; n++) begin
            if (bus_address == SCC_ADR_FREQ + 5'(2 * n)) begin
                rd_value = freq_lo_rd[n];
            end
            if (bus_address == SCC_ADR_FREQ + 5'(2 * n + 1)) begin
                rd_value = freq_hi_rd[n];
            end
            if (bus_address == SCC_ADR_VOL + 5'(n)) begin
                rd_value = vol_rd[n];
            end
        end
        if (bus_address == SCC_ADR_ENABLE) begin
            rd_value = {2'b00, ch_enable};
        end
    end

    // Read data is captured from the current (pre-write) register values, so a
    // same-cycle write to the same offset is not visible until the next read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot         <= '0;
            ch_enable    <= '0;
            bus_rdata    <= '0;
            bus_rdata_en <= 1'b0;
        end else begin
            if (slot_en) begin
                slot <= scc_next_slot(slot);
            end
            if (bus_wr && (bus_address == SCC_ADR_ENABLE)) begin
                ch_enable <= bus_wdata[5:0];
            end
            bus_rdata_en <= bus_rd;
            if (bus_rd) begin
                bus_rdata <= rd_value;
            end
        end
    end

    assign pending_ext = {2'b00, pending};
    assign reload      = pending_ext[slot];
    assign active      = slot;

    assign freq_a = freq_arr[0];
    assign freq_b = freq_arr[1];
    assign freq_c = freq_arr[2];
    assign freq_d = freq_arr[3];
    assign freq_e = freq_arr[4];
    assign freq_f = freq_arr[5];
    assign vol_a  = vol_arr[0];
    assign vol_b  = vol_arr[1];
    assign vol_c  = vol_arr[2];
    assign vol_d  = vol_arr[3];
    assign vol_e  = vol_arr[4];
    assign vol_f  = vol_arr[5];

endmodule
